switch_module: RTL and testbench
================================

SWITCH_MODULE -- requirements
Module: switch_module

Interface
REQ-001 SHALL have parameter PORT_NUB, default 4, number of switch ports; legal values are powers of two, 2 or more; W = log2(PORT_NUB).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 8, entries per virtual output queue; legal values are powers of two.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state changes occur on the rising edge.
REQ-006 rst_n  input  1  asynchronous reset, asserted high despite the port name.
REQ-007 port_in  input  PORT_NUB*(1+2W+DATA_WIDTH)  one slot per input port p at [(p+1)*S-1 : p*S], where S = 1+2W+DATA_WIDTH.
- Slot fields, MSB to LSB: valid(1), rx_port(W) = destination, tx_port(W) = source tag, data(DATA_WIDTH).
REQ-008 port_out  output  PORT_NUB*DATA_WIDTH  read data for output port i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-009 rd_sel  input  PORT_NUB*W  field i selects the source queue that output port i reads from.
REQ-010 rd_en  input  PORT_NUB  bit i requests a pop for output port i.
REQ-011 empty  output  PORT_NUB*PORT_NUB  bit [i*PORT_NUB+j] = 1 when the queue from source j to destination i is empty.
REQ-012 full  output  1  asserted when any queue is full.

Function
REQ-013 SHALL implement PORT_NUB*PORT_NUB independent FIFOs Q(i,j): destination i, source j, each QUEUE_DEPTH x DATA_WIDTH.
REQ-014 Write rule: on each rising edge, for every input port p with valid=1, data SHALL be pushed into Q(rx_port, p).
- The queue is indexed by physical port p; the tx_port field is ignored.
REQ-015 All PORT_NUB inputs SHALL be able to write in the same cycle, including several inputs targeting the same destination; no arbitration and no loss while the target queues are not full.
REQ-016 A write to a full queue SHALL be dropped silently; the queue contents and pointers stay unchanged.
REQ-017 Read rule: on a rising edge with rd_en[i]=1 and Q(i, rd_sel[i]) non-empty, the head entry SHALL be popped and registered onto port_out slot i.
- port_out is valid the cycle after the rd_en edge (1-cycle latency).
REQ-018 rd_en[i]=1 on an empty queue SHALL have no effect; port_out slot i keeps its previous value.
REQ-019 port_out slot i SHALL hold its last read value while rd_en[i]=0.
REQ-020 A simultaneous push and pop on the same queue SHALL both take effect and leave the occupancy unchanged.
- This applies even when the queue is full: the pop frees the slot for the push in the same cycle.
REQ-021 Each queue SHALL use wrap-around read/write pointers plus an occupancy count of log2(QUEUE_DEPTH)+1 bits; data order is strictly FIFO.
REQ-022 empty and full SHALL be combinational functions of the registered occupancy counts; they reflect writes and reads one cycle after the edge.
REQ-023 Different output ports SHALL be able to read independently in the same cycle, including from the same source j, since these are different queues.

Reset
REQ-024 While rst_n=1, all queue pointers and counts SHALL clear immediately (asynchronous), all empty bits SHALL be 1, full SHALL be 0, and port_out SHALL be all zeros.
REQ-025 Reset asserted mid-transfer SHALL discard all queued data; the first write after release is the first entry of its queue.
REQ-026 Inputs SHALL be ignored while reset is asserted.

Verification
REQ-027 Reset: assert rst_n=1 mid-run -> empty all ones, full=0, port_out=0 without waiting for a clock edge.
REQ-028 Single flow: port 1 sends valid data 0x11, 0x12, 0x13 to rx_port=2 on 3 consecutive cycles.
- empty[2*4+1] drops one cycle after the first write.
- rd_sel[2]=1 with rd_en[2] held for 3 cycles -> port_out slot 2 shows 0x11, 0x12, 0x13 in order, each one cycle after its rd_en edge.
- empty[9] returns to 1.
REQ-029 Contention: ports 0..3 all send to destination 0 in the same cycle with data 0x0p -> empty[0..3] all 0.
- Reading rd_sel[0]=0,1,2,3 in turn returns 0x00, 0x01, 0x02, 0x03; nothing is lost.
REQ-030 Full: write 9 entries from port 0 to destination 3 with QUEUE_DEPTH=8 -> full=1 after the 8th write; the 9th is dropped.
- 8 reads return the first 8 values; full=0 after the first read.
REQ-031 Empty read: rd_en[1]=1 with an empty selected queue -> port_out slot 1 unchanged and all empty bits unchanged.
REQ-032 All-to-all: each port p sends data p*10+d to every destination d in rotation.
- Each output drains every non-empty queue it selects; every port_out value equals its source*10+destination, and per-queue order is preserved.

Source files
------------

// File: rtl/switch_module.sv
// Crossbar switch with one virtual output queue per (destination, source) pair.
// Every input can push in the same cycle; each output pops from the queue it selects with rd_sel.
module switch_module #(
  parameter int PORT_NUB    = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic [PORT_NUB*(1+2*$clog2(PORT_NUB)+DATA_WIDTH)-1:0]    port_in,
  output logic [PORT_NUB*DATA_WIDTH-1:0]                           port_out,
  input  logic [PORT_NUB*$clog2(PORT_NUB)-1:0]                     rd_sel,
  input  logic [PORT_NUB-1:0]                                      rd_en,
  output logic [PORT_NUB*PORT_NUB-1:0]                             empty,
  output logic                                                     full
);

  localparam int W  = $clog2(PORT_NUB);
  localparam int S  = 1 + 2*W + DATA_WIDTH;
  localparam int NQ = PORT_NUB*PORT_NUB;
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr [NQ];
  logic [AW-1:0]         rd_ptr [NQ];
  logic [CW-1:0]         cnt    [NQ];
  logic [DATA_WIDTH-1:0] mem    [NQ][QUEUE_DEPTH];
  logic [NQ-1:0]         push;
  logic [NQ-1:0]         pop;
  logic [DATA_WIDTH-1:0] head   [PORT_NUB];
  logic [PORT_NUB-1:0]   rd_hit;
  logic                  unused_tx;

  // Queue index is i*PORT_NUB + j: destination i, physical source port j.
  // A full queue still accepts a push when it is popped in the same cycle.
  always_comb begin
    push   = '0;
    pop    = '0;
    rd_hit = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      head[i] = '0;
      for (int j = 0; j < PORT_NUB; j++) begin
        pop[i*PORT_NUB+j] = rd_en[i] && (rd_sel[i*W +: W] == W'(j)) &&
                            (cnt[i*PORT_NUB+j] != '0);
        push[i*PORT_NUB+j] = port_in[j*S+S-1] &&
                             (port_in[j*S+DATA_WIDTH+W +: W] == W'(i)) &&
                             ((cnt[i*PORT_NUB+j] != CW'(QUEUE_DEPTH)) || pop[i*PORT_NUB+j]);
        if (pop[i*PORT_NUB+j]) begin
          head[i]   = mem[i*PORT_NUB+j][rd_ptr[i*PORT_NUB+j]];
          rd_hit[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    full = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      empty[q] = (cnt[q] == '0);
      full     = full | (cnt[q] == CW'(QUEUE_DEPTH));
    end
  end

  // The source tag field carries no routing meaning here.
  always_comb begin
    unused_tx = 1'b0;
    for (int p = 0; p < PORT_NUB; p++)
      unused_tx = unused_tx ^ (^port_in[p*S+DATA_WIDTH +: W]);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        cnt[q]    <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (push[q]) wr_ptr[q] <= wr_ptr[q] + 1'b1;
        if (pop[q])  rd_ptr[q] <= rd_ptr[q] + 1'b1;
        if (push[q] && !pop[q])      cnt[q] <= cnt[q] + 1'b1;
        else if (pop[q] && !push[q]) cnt[q] <= cnt[q] - 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int q = 0; q < NQ; q++)
      if (push[q])
        mem[q][wr_ptr[q]] <= port_in[(q % PORT_NUB)*S +: DATA_WIDTH];
  end

  // Output stage: holds its last popped value until the next successful pop.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      port_out <= '0;
    end else begin
      for (int i = 0; i < PORT_NUB; i++)
        if (rd_hit[i]) port_out[i*DATA_WIDTH +: DATA_WIDTH] <= head[i];
    end
  end

endmodule

// File: tb/tb_switch_module.sv
// Directed bench for switch_module with default parameters (4 ports, 8-bit data, depth 8).
module tb_switch_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [51:0] port_in;
  logic [31:0] port_out;
  logic [7:0]  rd_sel;
  logic [3:0]  rd_en;
  logic [15:0] empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  switch_module #(.PORT_NUB(4), .DATA_WIDTH(8), .QUEUE_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .port_in(port_in), .port_out(port_out),
    .rd_sel(rd_sel), .rd_en(rd_en), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int p, input logic v, input logic [1:0] rx, input logic [7:0] d);
    port_in[p*13 +: 13] = {v, rx, 2'b00, d};
  endtask

  function automatic logic [7:0] slot_out(input int i);
    return port_out[i*8 +: 8];
  endfunction

  initial begin
    rst_n   = 1'b1;
    port_in = '0;
    rd_sel  = '0;
    rd_en   = '0;
    #1;
    chk("reset_empty", empty, 16'hFFFF);
    chk("reset_full", full, 0);
    chk("reset_out", port_out, 0);
    step();
    step();
    rst_n = 1'b0;

    // Single flow: port 1 -> destination 2
    set_slot(1, 1'b1, 2'd2, 8'h11);
    step();
    chk("flow_empty9_low", empty, 16'hFDFF);
    set_slot(1, 1'b1, 2'd2, 8'h12);
    step();
    set_slot(1, 1'b1, 2'd2, 8'h13);
    step();
    port_in = '0;
    rd_sel[5:4] = 2'd1;
    rd_en = 4'b0100;
    step();
    chk("flow_rd0", slot_out(2), 8'h11);
    step();
    chk("flow_rd1", slot_out(2), 8'h12);
    step();
    chk("flow_rd2", slot_out(2), 8'h13);
    rd_en = '0;
    chk("flow_empty_back", empty, 16'hFFFF);
    step();
    chk("flow_hold", slot_out(2), 8'h13);

    // Read of an empty queue changes nothing
    rd_sel[3:2] = 2'd0;
    rd_en = 4'b0010;
    step();
    rd_en = '0;
    chk("emptyrd_out", port_out, 32'h0013_0000);
    chk("emptyrd_empty", empty, 16'hFFFF);

    // Contention: all ports -> destination 0 in one cycle
    for (int p = 0; p < 4; p++) set_slot(p, 1'b1, 2'd0, 8'(p));
    step();
    port_in = '0;
    chk("cont_empty", empty, 16'hFFF0);
    rd_en = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      rd_sel[1:0] = 2'(j);
      step();
      chk($sformatf("cont_rd%0d", j), slot_out(0), 8'(j));
    end
    rd_en = '0;
    chk("cont_drained", empty, 16'hFFFF);

    // Full: 9 writes port 0 -> destination 3, the 9th is dropped
    for (int k = 0; k < 9; k++) begin
      set_slot(0, 1'b1, 2'd3, 8'hA0 + 8'(k));
      step();
      if (k == 6) chk("full_after7", full, 0);
      if (k == 7) chk("full_after8", full, 1);
    end
    port_in = '0;
    chk("full_after9", full, 1);
    chk("full_empty", empty, 16'hEFFF);
    rd_sel[7:6] = 2'd0;
    rd_en = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("full_rd%0d", k), slot_out(3), 8'hA0 + 8'(k));
      if (k == 0) chk("full_clear", full, 0);
    end
    step();
    rd_en = '0;
    chk("full_dropped", slot_out(3), 8'hA7);
    chk("full_drained", empty, 16'hFFFF);

    // Push and pop on a full queue in the same cycle
    for (int k = 0; k < 8; k++) begin
      set_slot(0, 1'b1, 2'd3, 8'hB0 + 8'(k));
      step();
    end
    chk("pp_full", full, 1);
    set_slot(0, 1'b1, 2'd3, 8'hB8);
    rd_en = 4'b1000;
    step();
    port_in = '0;
    chk("pp_pop", slot_out(3), 8'hB0);
    chk("pp_still_full", full, 1);
    for (int k = 1; k < 9; k++) begin
      step();
      chk($sformatf("pp_rd%0d", k), slot_out(3), 8'hB0 + 8'(k));
    end
    rd_en = '0;
    chk("pp_drained", empty, 16'hFFFF);

    // All-to-all: port p sends p*10+d to destination d in rotation
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 4; p++) set_slot(p, 1'b1, 2'((p + c) % 4), 8'(p*10 + (p + c) % 4));
      step();
    end
    port_in = '0;
    chk("a2a_allfull", empty, 16'h0000);
    rd_en = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      rd_sel = {2'(j), 2'(j), 2'(j), 2'(j)};
      step();
      for (int i = 0; i < 4; i++)
        chk($sformatf("a2a_s%0d_d%0d", j, i), slot_out(i), 8'(j*10 + i));
    end
    rd_en = '0;
    chk("a2a_drained", empty, 16'hFFFF);

    // Mid-run asynchronous reset discards queued data
    set_slot(2, 1'b1, 2'd1, 8'h55);
    step();
    port_in = '0;
    chk("mid_empty6", empty, 16'hFFBF);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_empty", empty, 16'hFFFF);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_out", port_out, 0);
    set_slot(2, 1'b1, 2'd1, 8'h77);
    rd_en = 4'b1111;
    step();
    chk("rst_ignores_in", empty, 16'hFFFF);
    port_in = '0;
    rd_en = '0;
    rst_n = 1'b0;
    set_slot(2, 1'b1, 2'd1, 8'h66);
    step();
    port_in = '0;
    rd_sel = 8'b0000_1000;
    rd_en = 4'b0010;
    step();
    rd_en = '0;
    chk("post_rst_first", slot_out(1), 8'h66);
    chk("post_rst_empty", empty, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
